// File: rtl/phold_core.sv
// PHOLD discrete-event engine: loads NUM_EV initial timestamps, then keeps
// retiring the earliest event, scheduling a replacement and logging each
// retired event to memory until the global virtual time reaches END_TIME.
module phold_core #(
  parameter int NUM_MC_PORTS = 1,
  parameter int RTNCTL_WIDTH = 32,
  parameter int NUM_EV       = 8,
  parameter int END_TIME     = 1000
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [47:0]                          addr,
  output logic [13:0]                          gvt,
  output logic                                 rtn_vld,
  output logic [NUM_MC_PORTS-1:0]              mc_rq_vld,
  output logic [3*NUM_MC_PORTS-1:0]            mc_rq_cmd,
  output logic [4*NUM_MC_PORTS-1:0]            mc_rq_scmd,
  output logic [48*NUM_MC_PORTS-1:0]           mc_rq_vadr,
  output logic [2*NUM_MC_PORTS-1:0]            mc_rq_size,
  output logic [RTNCTL_WIDTH*NUM_MC_PORTS-1:0] mc_rq_rtnctl,
  output logic [64*NUM_MC_PORTS-1:0]           mc_rq_data,
  output logic [NUM_MC_PORTS-1:0]              mc_rq_flush,
  input  logic [NUM_MC_PORTS-1:0]              mc_rq_stall,
  input  logic [NUM_MC_PORTS-1:0]              mc_rs_vld,
  input  logic [3*NUM_MC_PORTS-1:0]            mc_rs_cmd,
  input  logic [4*NUM_MC_PORTS-1:0]            mc_rs_scmd,
  input  logic [RTNCTL_WIDTH*NUM_MC_PORTS-1:0] mc_rs_rtnctl,
  input  logic [64*NUM_MC_PORTS-1:0]           mc_rs_data,
  output logic [NUM_MC_PORTS-1:0]              mc_rs_stall
);

  localparam int IDX_W = $clog2(NUM_EV);
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic [2:0] {IDLE, INIT_RD, INIT_WAIT, PROC, DRAIN, DONE} state_t;

  state_t           state;
  logic [13:0]      slots [NUM_EV];
  logic [IDX_W-1:0] rd_idx;
  logic [CNT_W-1:0] rsp_cnt;
  logic [7:0]       log_k;
  logic [15:0]      wr_out;
  logic [15:0]      lfsr;

  logic [13:0]      min_ts;
  logic [IDX_W-1:0] min_idx;
  logic [13:0]      new_ts;
  logic             rd_issue;
  logic             proc_issue;
  logic             rd_rsp;
  logic             wr_cmp;
  logic             lfsr_fb;
  logic             unused_rs;

  assign mc_rq_scmd  = '0;
  assign mc_rq_flush = '0;
  assign mc_rs_stall = '0;
  assign unused_rs   = ^{mc_rq_stall, mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_rtnctl, mc_rs_data};

  assign lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign new_ts     = min_ts + 14'd1 + {10'd0, lfsr[3:0]};
  assign rd_issue   = (state == INIT_RD) && !mc_rq_stall[0];
  assign proc_issue = (state == PROC) && (min_ts < 14'(END_TIME)) && !mc_rq_stall[0];
  assign rd_rsp     = mc_rs_vld[0] && (mc_rs_cmd[2:0] == 3'd2) &&
                      ((state == INIT_RD) || (state == INIT_WAIT));
  assign wr_cmp     = mc_rs_vld[0] && (mc_rs_cmd[2:0] == 3'd3) &&
                      ((state == PROC) || (state == DRAIN)) && (wr_out != 16'd0);

  // Earliest pending event; strict compare keeps the lowest slot on ties
  always_comb begin
    min_ts  = slots[0];
    min_idx = '0;
    for (int i = 1; i < NUM_EV; i++) begin
      if (slots[i] < min_ts) begin
        min_ts  = slots[i];
        min_idx = IDX_W'(i);
      end
    end
  end

  // Port 0 request; valid is gated by stall so every valid cycle is accepted
  always_comb begin
    mc_rq_vld    = '0;
    mc_rq_cmd    = '0;
    mc_rq_vadr   = '0;
    mc_rq_size   = '0;
    mc_rq_rtnctl = '0;
    mc_rq_data   = '0;
    if (rd_issue) begin
      mc_rq_vld[0]                   = 1'b1;
      mc_rq_cmd[2:0]                 = 3'd1;
      mc_rq_size[1:0]                = 2'd3;
      mc_rq_vadr[47:0]               = addr + (48'(rd_idx) << 3);
      mc_rq_rtnctl[RTNCTL_WIDTH-1:0] = RTNCTL_WIDTH'(rd_idx);
    end else if (proc_issue) begin
      mc_rq_vld[0]                   = 1'b1;
      mc_rq_cmd[2:0]                 = 3'd2;
      mc_rq_size[1:0]                = 2'd3;
      mc_rq_vadr[47:0]               = addr + ((48'(NUM_EV) + 48'(log_k)) << 3);
      mc_rq_rtnctl[RTNCTL_WIDTH-1:0] = RTNCTL_WIDTH'(min_idx);
      mc_rq_data[63:0]               = {32'b0, 2'b0, min_ts, 2'b0, new_ts};
    end
  end

  // Main sequencer: load, process, drain outstanding writes, report once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      for (int i = 0; i < NUM_EV; i++) slots[i] <= '0;
      rd_idx  <= '0;
      rsp_cnt <= '0;
      log_k   <= '0;
      wr_out  <= '0;
      lfsr    <= 16'hACE1;
      gvt     <= '0;
      rtn_vld <= 1'b0;
    end else begin
      rtn_vld <= 1'b0;
      if (rd_rsp) begin
        slots[mc_rs_rtnctl[IDX_W-1:0]] <= mc_rs_data[13:0];
        rsp_cnt <= rsp_cnt + CNT_W'(1);
      end
      if (proc_issue && !wr_cmp) wr_out <= wr_out + 16'd1;
      else if (!proc_issue && wr_cmp) wr_out <= wr_out - 16'd1;
      case (state)
        IDLE: state <= INIT_RD;
        INIT_RD: begin
          if (rd_issue) begin
            rd_idx <= rd_idx + IDX_W'(1);
            if (rd_idx == IDX_W'(NUM_EV - 1)) state <= INIT_WAIT;
          end
        end
        INIT_WAIT: begin
          if (rsp_cnt == CNT_W'(NUM_EV)) state <= PROC;
        end
        PROC: begin
          gvt <= min_ts;
          if (min_ts >= 14'(END_TIME)) begin
            state <= DRAIN;
          end else if (proc_issue) begin
            slots[min_idx] <= new_ts;
            log_k          <= log_k + 8'd1;
            lfsr           <= {lfsr[14:0], lfsr_fb};
          end
        end
        DRAIN: begin
          if (wr_out == 16'd0) begin
            state   <= DONE;
            rtn_vld <= 1'b1;
          end
        end
        default: state <= DONE;
      endcase
    end
  end

endmodule

// File: tb/tb_phold_core.sv
// Scoreboard bench for phold_core: expected memory requests are queued when a
// run is set up; a monitor pops and compares each request the core issues,
// while a small memory model answers reads and write completions.
module tb_phold_core;

  localparam logic [47:0] BASE = 48'h0000_1234_5000;

  typedef struct packed {
    logic [2:0]  cmd;
    logic [47:0] adr;
    logic [63:0] dat;
    logic [31:0] tag;
  } req_t;

  typedef struct {
    int          due;
    logic [2:0]  cmd;
    logic [31:0] tag;
    logic [63:0] dat;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [47:0] addr = BASE;
  logic [13:0] gvt;
  logic        rtn_vld;
  logic [0:0]  mc_rq_vld;
  logic [2:0]  mc_rq_cmd;
  logic [3:0]  mc_rq_scmd;
  logic [47:0] mc_rq_vadr;
  logic [1:0]  mc_rq_size;
  logic [31:0] mc_rq_rtnctl;
  logic [63:0] mc_rq_data;
  logic [0:0]  mc_rq_flush;
  logic [0:0]  mc_rq_stall = 1'b0;
  logic [0:0]  mc_rs_vld = 1'b0;
  logic [2:0]  mc_rs_cmd = '0;
  logic [3:0]  mc_rs_scmd = '0;
  logic [31:0] mc_rs_rtnctl = '0;
  logic [63:0] mc_rs_data = '0;
  logic [0:0]  mc_rs_stall;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  req_t        exp_q [$];
  rsp_t        rsp_q [$];
  logic [13:0] init_ts [8];
  logic [13:0] exp_gvt;
  logic [13:0] last_gvt;
  logic [13:0] prev_gvt;
  logic [13:0] gvt1;
  logic [13:0] gvt_mid;
  bit          rev_mode = 1'b0;
  bit          stall_mode = 1'b0;
  int          wr_delay = 1;
  int          wr_issued, wr_done, rtn_cnt, rtn_cyc, last_wc_cyc, wr_seen, rd_held;
  bit          first_wr_seen;
  logic [63:0] first_wr_dat;
  logic [31:0] first_wr_tag;

  phold_core dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .gvt(gvt), .rtn_vld(rtn_vld),
    .mc_rq_vld(mc_rq_vld), .mc_rq_cmd(mc_rq_cmd), .mc_rq_scmd(mc_rq_scmd),
    .mc_rq_vadr(mc_rq_vadr), .mc_rq_size(mc_rq_size), .mc_rq_rtnctl(mc_rq_rtnctl),
    .mc_rq_data(mc_rq_data), .mc_rq_flush(mc_rq_flush), .mc_rq_stall(mc_rq_stall),
    .mc_rs_vld(mc_rs_vld), .mc_rs_cmd(mc_rs_cmd), .mc_rs_scmd(mc_rs_scmd),
    .mc_rs_rtnctl(mc_rs_rtnctl), .mc_rs_data(mc_rs_data), .mc_rs_stall(mc_rs_stall)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mem_word(input logic [31:0] tag);
    return {32'hDEAD_BEEF, 18'h2A5A5, init_ts[tag[2:0]]};
  endfunction

  // Reference PHOLD run: 8 loads, then retire/replace until min reaches 1000
  task automatic build_expected();
    logic [13:0] ts [8];
    logic [13:0] mn, nw;
    logic [15:0] l;
    int          mi;
    req_t        e;
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      e = '{cmd: 3'd1, adr: BASE + 48'(8 * i), dat: 64'd0, tag: 32'(i)};
      exp_q.push_back(e);
    end
    ts = init_ts;
    l  = 16'hACE1;
    for (int k = 0; k < 5000; k++) begin
      mn = ts[0];
      mi = 0;
      for (int i = 1; i < 8; i++) if (ts[i] < mn) begin mn = ts[i]; mi = i; end
      if (mn >= 14'd1000) begin
        exp_gvt = mn;
        break;
      end
      nw = mn + 14'd1 + {10'd0, l[3:0]};
      e = '{cmd: 3'd2, adr: BASE + 48'(8 * (8 + (k % 256))),
            dat: {32'b0, 2'b0, mn, 2'b0, nw}, tag: 32'(mi)};
      exp_q.push_back(e);
      ts[mi] = nw;
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    end
  endtask

  // Monitor, memory model and response driver share one process
  always begin : bench_proc
    req_t e;
    rsp_t r;
    @(negedge clk);
    if (!rst_n) begin
      rsp_q.delete();
      wr_issued = 0; wr_done = 0; rtn_cnt = 0; rtn_cyc = 0; last_wc_cyc = -1;
      wr_seen = 0; rd_held = 0; first_wr_seen = 1'b0; prev_gvt = '0;
    end else begin
      if (mc_rq_stall[0]) check_output("no_vld_when_stall", 64'(mc_rq_vld[0]), 64'd0);
      if (gvt != prev_gvt) begin
        check_output("gvt_monotonic", 64'(gvt > prev_gvt), 64'd1);
        prev_gvt = gvt;
      end
      if (mc_rq_vld[0]) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_req: got cmd=%0d adr=%0h expected no request", mc_rq_cmd, mc_rq_vadr);
        end else begin
          e = exp_q.pop_front();
          check_output("req_cmd", 64'(mc_rq_cmd), 64'(e.cmd));
          check_output("req_adr", 64'(mc_rq_vadr), 64'(e.adr));
          check_output("req_tag", 64'(mc_rq_rtnctl), 64'(e.tag));
          check_output("req_size", 64'(mc_rq_size), 64'd3);
          if (e.cmd == 3'd2) check_output("req_data", mc_rq_data, e.dat);
        end
        if (mc_rq_cmd == 3'd1) begin
          if (rev_mode) begin
            rd_held++;
            if (rd_held == 8) begin
              r = '{due: cyc + 1, cmd: 3'd1, tag: 32'd0, dat: 64'd0};
              rsp_q.push_back(r);
              for (int t = 7; t >= 0; t--) begin
                r = '{due: cyc + 1, cmd: 3'd2, tag: 32'(t), dat: mem_word(32'(t))};
                rsp_q.push_back(r);
              end
            end
          end else begin
            r = '{due: cyc + 2, cmd: 3'd2, tag: mc_rq_rtnctl, dat: mem_word(mc_rq_rtnctl)};
            rsp_q.push_back(r);
          end
        end else if (mc_rq_cmd == 3'd2) begin
          wr_issued++;
          wr_seen++;
          if (!first_wr_seen) begin
            first_wr_seen = 1'b1;
            first_wr_dat  = mc_rq_data;
            first_wr_tag  = mc_rq_rtnctl;
          end
          r = '{due: cyc + wr_delay, cmd: 3'd3, tag: mc_rq_rtnctl, dat: 64'd0};
          rsp_q.push_back(r);
        end
      end
      if (rtn_vld) begin
        rtn_cnt++;
        rtn_cyc  = cyc;
        last_gvt = gvt;
        check_output("final_gvt", 64'(gvt), 64'(exp_gvt));
        check_output("no_outstanding_at_rtn", 64'(wr_issued - wr_done), 64'd0);
        check_output("all_reqs_seen_at_rtn", 64'(exp_q.size()), 64'd0);
        check_output("rtn_after_last_wc", 64'(rtn_cyc > last_wc_cyc), 64'd1);
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    mc_rq_stall[0] = stall_mode ? 1'($urandom_range(0, 1)) : 1'b0;
    if (rst_n && rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
      r = rsp_q.pop_front();
      mc_rs_vld[0] = 1'b1;
      mc_rs_cmd    = r.cmd;
      mc_rs_rtnctl = r.tag;
      mc_rs_data   = r.dat;
      if (r.cmd == 3'd3) begin
        wr_done++;
        last_wc_cyc = cyc;
      end
    end else begin
      mc_rs_vld[0] = 1'b0;
      mc_rs_cmd    = '0;
      mc_rs_rtnctl = '0;
      mc_rs_data   = '0;
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check_output("reset_gvt", 64'(gvt), 64'd0);
    check_output("reset_rq_vld", 64'(mc_rq_vld), 64'd0);
    check_output("reset_rtn_vld", 64'(rtn_vld), 64'd0);
    repeat (3) @(posedge clk);
  endtask

  task automatic start_run(input bit rev, input bit stl, input int dly);
    do_reset();
    rev_mode   = rev;
    stall_mode = stl;
    wr_delay   = dly;
    build_expected();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic wait_done();
    int n = 0;
    while (rtn_cnt == 0 && n < 20000) begin
      @(posedge clk);
      n++;
    end
    if (rtn_cnt == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL timeout: got no rtn_vld after %0d cycles expected one pulse", n);
    end
    repeat (10) @(posedge clk);
    check_output("single_rtn_pulse", 64'(rtn_cnt), 64'd1);
  endtask

  task automatic apply_stimulus(input bit rev, input bit stl, input int dly);
    start_run(rev, stl, dly);
    wait_done();
  endtask

  initial begin
    int n;
    $display("[TB] baseline run, timestamps 0..7");
    init_ts = '{14'd0, 14'd1, 14'd2, 14'd3, 14'd4, 14'd5, 14'd6, 14'd7};
    apply_stimulus(1'b0, 1'b0, 1);
    check_output("first_write_data", first_wr_dat, 64'h0000_0000_0000_0002);
    check_output("first_write_tag", 64'(first_wr_tag), 64'd0);
    check_output("gvt_in_range", 64'((last_gvt >= 14'd1000) && (last_gvt <= 14'd1015)), 64'd1);
    gvt1 = last_gvt;

    $display("[TB] all timestamps past END_TIME");
    init_ts = '{14'd1200, 14'd1005, 14'd1100, 14'd1300, 14'd1001, 14'd1500, 14'd1002, 14'd1999};
    apply_stimulus(1'b0, 1'b0, 1);
    check_output("early_stop_gvt", 64'(last_gvt), 64'd1001);
    check_output("early_stop_no_writes", 64'(wr_seen), 64'd0);

    $display("[TB] reverse-order read responses");
    init_ts = '{14'd500, 14'd40, 14'd300, 14'd25, 14'd700, 14'd600, 14'd33, 14'd900};
    apply_stimulus(1'b1, 1'b0, 1);
    check_output("rev_first_write_data", first_wr_dat, 64'h0000_0000_0019_001B);
    check_output("rev_first_write_tag", 64'(first_wr_tag), 64'd3);

    $display("[TB] random request stall");
    init_ts = '{14'd0, 14'd1, 14'd2, 14'd3, 14'd4, 14'd5, 14'd6, 14'd7};
    apply_stimulus(1'b0, 1'b1, 1);
    check_output("stall_gvt_same", 64'(last_gvt), 64'(gvt1));

    $display("[TB] write completions delayed 20 cycles");
    apply_stimulus(1'b0, 1'b0, 20);
    check_output("slow_wc_gvt_same", 64'(last_gvt), 64'(gvt1));

    $display("[TB] reset in the middle of processing");
    start_run(1'b0, 1'b0, 1);
    n = 0;
    while (wr_seen < 50 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    gvt_mid = gvt;
    check_output("progress_before_reset", 64'(gvt_mid > 14'd0), 64'd1);
    apply_stimulus(1'b0, 1'b0, 1);
    check_output("restart_gvt_same", 64'(last_gvt), 64'(gvt1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
